// File: rtl/pueo_command_scheduler.sv
// pueo_command_scheduler
//
// Builds one 32-bit command word per command slot. A slot is SLOT_LEN sysclk
// cycles long. Each word can carry three things at once: one trigger timestamp
// taken from a small FIFO, one pending run command, and one mode1 byte taken
// from an AXI-Stream input.
//
// Ports
//   sysclk_i         : sole clock
//   rst_i            : asynchronous, active-high reset
//   trig_time_i      : 14-bit trigger timestamp
//   trig_valid_i     : push strobe, one FIFO entry per cycle while high
//   trig_overflow_o  : sticky flag, set when a trigger was dropped on a full FIFO
//   runcmd_i         : run command code (01 DO_SYNC, 10 RESET, 11 STOP)
//   runcmd_valid_i   : run command request
//   runcmd_ready_o   : high while no run command is waiting for a slot
//   s_tdata/s_tuser  : mode1 byte and its type
//   s_tvalid/s_tready: AXI-Stream handshake; ready only on the build cycle
//   command_o        : composed command word, held between build edges
//   command_valid_o  : one-cycle strobe for each new word
module pueo_command_scheduler #(
    parameter int TRIG_DEPTH = 4,
    parameter int SLOT_LEN   = 8
) (
    input  logic        sysclk_i,
    input  logic        rst_i,
    input  logic [13:0] trig_time_i,
    input  logic        trig_valid_i,
    output logic        trig_overflow_o,
    input  logic [1:0]  runcmd_i,
    input  logic        runcmd_valid_i,
    output logic        runcmd_ready_o,
    input  logic [7:0]  s_tdata,
    input  logic [1:0]  s_tuser,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [31:0] command_o,
    output logic        command_valid_o
);

    localparam int AW = $clog2(TRIG_DEPTH);
    localparam int SW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_LEN - 1);
    localparam logic [31:0]   IDLE_WORD = 32'h8000_0000;

    logic [SW-1:0] slot_cnt_q, slot_cnt_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic          run_pending_q, run_pending_d;
    logic [1:0]    run_code_q, run_code_d;
    logic [31:0]   command_q, command_d;
    logic          command_valid_q, command_valid_d;

    logic [13:0]   fifo_mem [TRIG_DEPTH];
    logic [13:0]   fifo_head;
    logic          fifo_empty;
    logic          fifo_full;
    logic          build_edge;
    logic          trig_pop;
    logic          trig_push;
    logic          run_accept;
    logic          mode1_xfer;
    logic          msg_present;

    assign build_edge = (slot_cnt_q == SLOT_LAST);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr_q[AW-1:0]];

    // A pop on the same edge frees a slot, so a push into a full FIFO is kept.
    // The head is read before the edge, so a same-edge push never bypasses.
    assign trig_pop  = build_edge && !fifo_empty;
    assign trig_push = trig_valid_i && (!fifo_full || trig_pop);

    // Ready is forced low during reset so nothing is handshaken while held.
    assign runcmd_ready_o = !run_pending_q && !rst_i;
    assign s_tready       = build_edge && !rst_i;
    assign run_accept     = runcmd_valid_i && runcmd_ready_o && (runcmd_i != 2'b00);
    assign mode1_xfer     = s_tvalid && s_tready;
    assign msg_present    = run_pending_q || mode1_xfer;

    always_comb begin
        slot_cnt_d      = build_edge ? '0 : slot_cnt_q + 1'b1;
        wr_ptr_d        = trig_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d        = trig_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        overflow_d      = overflow_q || (trig_valid_i && fifo_full && !trig_pop);
        run_pending_d   = run_pending_q;
        run_code_d      = run_code_q;
        command_d       = command_q;
        command_valid_d = build_edge;

        // The pending command leaves on this build edge; ready is low here,
        // so no new request can be accepted on the same edge.
        if (build_edge && run_pending_q) begin
            run_pending_d = 1'b0;
        end else if (run_accept) begin
            run_pending_d = 1'b1;
            run_code_d    = runcmd_i;
        end

        if (build_edge) begin
            command_d = {
                !msg_present,
                3'b000,
                run_pending_q ? run_code_q : 2'b00,
                mode1_xfer    ? s_tuser    : 2'b00,
                mode1_xfer    ? s_tdata    : 8'h00,
                trig_pop,
                1'b0,
                trig_pop      ? fifo_head  : 14'd0
            };
        end
    end

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_cnt_q      <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            overflow_q      <= 1'b0;
            run_pending_q   <= 1'b0;
            run_code_q      <= 2'b00;
            command_q       <= IDLE_WORD;
            command_valid_q <= 1'b0;
        end else begin
            slot_cnt_q      <= slot_cnt_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            overflow_q      <= overflow_d;
            run_pending_q   <= run_pending_d;
            run_code_q      <= run_code_d;
            command_q       <= command_d;
            command_valid_q <= command_valid_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge sysclk_i) begin
        if (trig_push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= trig_time_i;
        end
    end

    assign trig_overflow_o = overflow_q;
    assign command_o       = command_q;
    assign command_valid_o = command_valid_q;

endmodule

// File: tb/tb_pueo_command_scheduler.sv
module tb_pueo_command_scheduler;

    localparam int SLOT = 8;

    logic        sysclk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [13:0] trig_time_i = '0;
    logic        trig_valid_i = 1'b0;
    logic        trig_overflow_o;
    logic [1:0]  runcmd_i = '0;
    logic        runcmd_valid_i = 1'b0;
    logic        runcmd_ready_o;
    logic [7:0]  s_tdata = '0;
    logic [1:0]  s_tuser = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] command_o;
    logic        command_valid_o;

    pueo_command_scheduler #(.TRIG_DEPTH(4), .SLOT_LEN(SLOT)) dut (
        .sysclk_i        (sysclk_i),
        .rst_i           (rst_i),
        .trig_time_i     (trig_time_i),
        .trig_valid_i    (trig_valid_i),
        .trig_overflow_o (trig_overflow_o),
        .runcmd_i        (runcmd_i),
        .runcmd_valid_i  (runcmd_valid_i),
        .runcmd_ready_o  (runcmd_ready_o),
        .s_tdata         (s_tdata),
        .s_tuser         (s_tuser),
        .s_tvalid        (s_tvalid),
        .s_tready        (s_tready),
        .command_o       (command_o),
        .command_valid_o (command_valid_o)
    );

    always #5 sysclk_i = ~sysclk_i;

    logic [31:0] exp_q[$];
    int          vectors = 0;
    int          fails = 0;
    int          edge_cnt = 0;
    int          word_idx = 0;
    logic [31:0] last_word = 32'h8000_0000;

    // Rising edges since the most recent reset release.
    always @(posedge sysclk_i) begin
        if (rst_i) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    // Monitor: pulse timing, word contents from the scoreboard, and hold.
    always @(negedge sysclk_i) begin
        logic        exp_pulse;
        logic [31:0] w;
        if (rst_i) begin
            last_word = 32'h8000_0000;
        end else begin
            exp_pulse = (edge_cnt != 0) && (edge_cnt % SLOT == 0);
            if (command_valid_o || exp_pulse) begin
                vectors++;
                if (command_valid_o !== exp_pulse) begin
                    fails++;
                    $display("FAIL pulse_timing edge %0d: valid=%0b expected %0b",
                             edge_cnt, command_valid_o, exp_pulse);
                end
            end
            if (command_valid_o) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL word_unexpected: got 0x%08h, expected no word", command_o);
                end else begin
                    w = exp_q.pop_front();
                    $display("word %0d at edge %0d: got 0x%08h expected 0x%08h",
                             word_idx, edge_cnt, command_o, w);
                    word_idx++;
                    if (command_o !== w) begin
                        fails++;
                        $display("FAIL word: got 0x%08h expected 0x%08h", command_o, w);
                    end
                    last_word = w;
                end
            end else begin
                vectors++;
                if (command_o !== last_word) begin
                    fails++;
                    $display("FAIL hold: got 0x%08h expected 0x%08h", command_o, last_word);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk_i);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_command"},  command_o, 32'h8000_0000);
        check({tag, "_valid"},    {31'd0, command_valid_o}, 32'd0);
        check({tag, "_tready"},   {31'd0, s_tready}, 32'd0);
        check({tag, "_runready"}, {31'd0, runcmd_ready_o}, 32'd0);
        check({tag, "_overflow"}, {31'd0, trig_overflow_o}, 32'd0);
    endtask

    initial begin
        // Reset state; every scenario below starts at phase 0 of a slot.
        tick(3);
        check_reset_outputs("reset");
        rst_i = 1'b0;

        // Idle slots; s_tready only on the build cycle.
        exp_q.push_back(32'h8000_0000);
        exp_q.push_back(32'h8000_0000);
        check("tready_phase0", {31'd0, s_tready}, 32'd0);
        tick(7);
        check("tready_phase7", {31'd0, s_tready}, 32'd1);
        tick(9);

        // Single trigger at cycle 2; then a trigger on the build edge of an
        // empty FIFO must wait for the following slot.
        exp_q.push_back(32'h8000_9234);
        tick(2);
        trig_valid_i = 1'b1; trig_time_i = 14'h1234;
        tick(1);
        trig_valid_i = 1'b0;
        tick(5);
        exp_q.push_back(32'h8000_0000);
        exp_q.push_back(32'h8000_8ABC);
        tick(7);
        trig_valid_i = 1'b1; trig_time_i = 14'h0ABC;
        tick(1);
        trig_valid_i = 1'b0;
        tick(8);

        // Fill FIFO, push on the popping build edge (kept), then one more
        // with no pop (dropped, overflow set).
        for (int i = 1; i <= 5; i++) exp_q.push_back(32'h8000_8000 | i);
        exp_q.push_back(32'h8000_0000);
        tick(3);
        for (int i = 1; i <= 4; i++) begin
            trig_valid_i = 1'b1; trig_time_i = 14'(i);
            tick(1);
        end
        trig_time_i = 14'd5;
        tick(1);
        check("overflow_after_full_pop_push", {31'd0, trig_overflow_o}, 32'd0);
        trig_time_i = 14'd6;
        tick(1);
        trig_valid_i = 1'b0;
        check("overflow_after_drop", {31'd0, trig_overflow_o}, 32'd1);
        tick(7);
        tick(32);

        // Run command + mode1 byte + trigger in one slot; STOP presented on
        // the transmit edge is refused.
        exp_q.push_back(32'h05A5_BFFF);
        exp_q.push_back(32'h8000_0000);
        tick(2);
        check("runready_before", {31'd0, runcmd_ready_o}, 32'd1);
        runcmd_valid_i = 1'b1; runcmd_i = 2'b01;
        tick(1);
        runcmd_valid_i = 1'b0;
        check("runready_after_accept", {31'd0, runcmd_ready_o}, 32'd0);
        s_tvalid = 1'b1; s_tdata = 8'hA5; s_tuser = 2'b01;
        tick(1);
        check("tready_phase4", {31'd0, s_tready}, 32'd0);
        trig_valid_i = 1'b1; trig_time_i = 14'h3FFF;
        tick(1);
        trig_valid_i = 1'b0;
        tick(2);
        check("runready_on_transmit", {31'd0, runcmd_ready_o}, 32'd0);
        runcmd_valid_i = 1'b1; runcmd_i = 2'b11;
        tick(1);
        s_tvalid = 1'b0;
        runcmd_valid_i = 1'b0;
        check("runready_after_transmit", {31'd0, runcmd_ready_o}, 32'd1);
        tick(7);
        check("stop_not_accepted", {31'd0, runcmd_ready_o}, 32'd1);
        tick(1);

        // Code 00 is accepted and discarded.
        exp_q.push_back(32'h8000_0000);
        tick(1);
        runcmd_valid_i = 1'b1; runcmd_i = 2'b00;
        tick(1);
        runcmd_valid_i = 1'b0;
        check("code00_discarded", {31'd0, runcmd_ready_o}, 32'd1);
        tick(6);

        // Continuous AXI stream: one byte per slot, tuser passed unmodified.
        exp_q.push_back(32'h0111_0000);
        exp_q.push_back(32'h0122_0000);
        exp_q.push_back(32'h0333_0000);
        exp_q.push_back(32'h0244_0000);
        exp_q.push_back(32'h8000_0000);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d [4];
            logic [1:0] u [4];
            d = '{8'h11, 8'h22, 8'h33, 8'h44};
            u = '{2'b01, 2'b01, 2'b11, 2'b10};
            s_tvalid = 1'b1; s_tdata = d[i]; s_tuser = u[i];
            tick(8);
        end
        s_tvalid = 1'b0;
        tick(8);

        // Mid-slot reset with two triggers queued and a run command pending.
        tick(1);
        trig_valid_i = 1'b1; trig_time_i = 14'h0100;
        tick(1);
        trig_time_i = 14'h0200;
        runcmd_valid_i = 1'b1; runcmd_i = 2'b10;
        tick(1);
        trig_valid_i = 1'b0;
        runcmd_valid_i = 1'b0;
        tick(1);
        #2;
        rst_i = 1'b1;
        exp_q.delete();
        #1;
        check_reset_outputs("midreset");
        tick(3);
        rst_i = 1'b0;
        exp_q.push_back(32'h8000_0000);
        exp_q.push_back(32'h8000_0000);
        exp_q.push_back(32'h8000_0000);
        tick(1);
        check("runready_after_midreset", {31'd0, runcmd_ready_o}, 32'd1);
        tick(23);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
        vectors++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d words outstanding, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/pueo_command_scheduler.md
PUEO_COMMAND_SCHEDULER -- requirements
Module: pueo_command_scheduler

Interface
REQ-001 SHALL have parameter TRIG_DEPTH, default 4, trigger FIFO depth; power of 2, range 2..16.
REQ-002 SHALL have parameter SLOT_LEN, default 8, sysclk cycles per command slot; 8 gives 125 MHz / 8 = 15.625 MHz.
REQ-003 SHALL have port sysclk_i, input, 1 bit: sole clock.
REQ-004 SHALL have port rst_i, input, 1 bit: reset; asynchronous, active-high.
REQ-005 SHALL have port trig_time_i, input, 14 bits: trigger timestamp.
REQ-006 SHALL have port trig_valid_i, input, 1 bit: trigger push strobe, one entry per cycle high.
REQ-007 SHALL have port trig_overflow_o, output, 1 bit: sticky flag, trigger dropped.
REQ-008 SHALL have port runcmd_i, input, 2 bits: 01 DO_SYNC, 10 RESET, 11 STOP.
REQ-009 SHALL have port runcmd_valid_i, input, 1 bit: run command request.
REQ-010 SHALL have port runcmd_ready_o, output, 1 bit: run command slot free.
REQ-011 SHALL have port s_tdata, input, 8 bits: mode1 byte.
REQ-012 SHALL have port s_tuser, input, 2 bits: mode1 type (00 special, 01 normal, 11 last/fw).
REQ-013 SHALL have port s_tvalid, input, 1 bit: AXI-Stream valid.
REQ-014 SHALL have port s_tready, output, 1 bit: AXI-Stream ready.
REQ-015 SHALL have port command_o, output, 32 bits: composed command word.
REQ-016 SHALL have port command_valid_o, output, 1 bit: one-cycle strobe per slot.

Function
REQ-017 SHALL run a free-running slot counter 0..SLOT_LEN-1 with wrap; the "build edge" is the rising edge at which the counter equals SLOT_LEN-1.
REQ-018 SHALL, on every build edge, register a new command_o and set command_valid_o=1; command_valid_o SHALL be 0 on all other cycles, and command_o SHALL hold between build edges.
REQ-019 SHALL use the following word format:
 - [31]: 0 if a message (run command or mode1 byte) is carried, else 1.
 - [30:28] and [14]: 0.
 - [27:26]: run command, or 00.
 - [25:24]: mode1 type, or 00.
 - [23:16]: mode1 data, or 00.
 - [15]: trigger present.
 - [13:0]: trigger time, or 0.
REQ-020 SHALL let one slot carry one trigger, one run command and one mode1 byte simultaneously.
REQ-021 SHALL push trig_time_i into the FIFO on each cycle where trig_valid_i=1 and the FIFO is not full.
 - Full and a pop on the same edge: the push is accepted.
 - Full and no pop: the entry is dropped and trig_overflow_o is set; it clears only on reset.
REQ-022 SHALL pop the oldest FIFO entry on a build edge if the FIFO is non-empty at that edge.
 - A push on the build edge itself is not sent until the next slot; there is no bypass.
REQ-023 SHALL preserve FIFO order; pointers are log2(TRIG_DEPTH)+1 bits with wrap-around.
REQ-024 SHALL drive runcmd_ready_o = !run_pending.
 - runcmd_valid_i && runcmd_ready_o with runcmd_i!=00 sets run_pending and latches the code.
 - Code 00 is accepted and discarded.
REQ-025 SHALL clear run_pending on the build edge that transmits it; runcmd_ready_o rises the cycle after.
 - A request presented on that edge is not accepted.
REQ-026 SHALL assert s_tready combinationally only while the slot counter equals SLOT_LEN-1.
 - A transfer (s_tvalid && s_tready) places s_tdata/s_tuser into the word built on that edge.
 - s_tuser is passed unmodified, including reserved 10.
REQ-027 SHALL accept at most one mode1 byte per slot; bytes are never dropped or reordered.
REQ-028 SHALL emit an idle word (0x8000_0000, plus trigger bits if a trigger is present) when no message is available.

Reset
REQ-029 SHALL, while rst_i=1, asynchronously force:
 - slot counter=0, FIFO empty, run_pending=0, trig_overflow_o=0.
 - command_o=0x8000_0000, command_valid_o=0.
REQ-030 SHALL hold s_tready=0 and runcmd_ready_o=0 while rst_i=1.
REQ-031 SHALL produce the first command_valid_o pulse on the SLOT_LEN-th rising edge after rst_i deasserts; reset mid-slot SHALL discard all pending content.

Verification
REQ-032 Idle -> command_valid_o every 8 cycles, command_o=0x8000_0000, first pulse at edge 8 after reset release.
REQ-033 trig_time_i=0x1234 pulsed at cycle 2 -> next word=0x8000_9234; five triggers back-to-back (depth 4, no pop) -> trig_overflow_o=1, four oldest sent in order over four slots.
REQ-034 runcmd_i=01 held valid, with s_tdata=0xA5 and s_tuser=01 -> one word 0x05A5_0000, then idle; runcmd_ready_o low from accept edge to the edge after transmit.
REQ-035 AXI stream of 3 bytes with continuous s_tvalid (last byte tuser=11) -> one byte per slot; words 0x01xx_0000 ×2 then 0x03xx_0000; no drops.
REQ-036 rst_i asserted mid-slot with FIFO holding 2 entries and a run command pending -> outputs reset immediately; after release, only idle words until new requests.
